// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : ALU op codes, execute-stage FSM states and shared helpers.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [5:0] c_ALU_BUBBLE = 6'h00;
    localparam logic [5:0] c_ALU_ADDI   = 6'h01;
    localparam logic [5:0] c_ALU_SLTI   = 6'h02;
    localparam logic [5:0] c_ALU_SLTIU  = 6'h03;
    localparam logic [5:0] c_ALU_XORI   = 6'h04;
    localparam logic [5:0] c_ALU_ORI    = 6'h05;
    localparam logic [5:0] c_ALU_ANDI   = 6'h06;
    localparam logic [5:0] c_ALU_SLLI   = 6'h07;
    localparam logic [5:0] c_ALU_SRLI   = 6'h08;
    localparam logic [5:0] c_ALU_SRAI   = 6'h09;
    localparam logic [5:0] c_ALU_ADD    = 6'h0C;
    localparam logic [5:0] c_ALU_SUB    = 6'h0D;
    localparam logic [5:0] c_ALU_SLL    = 6'h0E;
    localparam logic [5:0] c_ALU_SLT    = 6'h0F;
    localparam logic [5:0] c_ALU_SLTU   = 6'h10;
    localparam logic [5:0] c_ALU_XOR    = 6'h11;
    localparam logic [5:0] c_ALU_SRL    = 6'h12;
    localparam logic [5:0] c_ALU_SRA    = 6'h13;
    localparam logic [5:0] c_ALU_OR     = 6'h14;
    localparam logic [5:0] c_ALU_AND    = 6'h15;
    localparam logic [5:0] c_ALU_ADDIW  = 6'h16;
    localparam logic [5:0] c_ALU_SLLIW  = 6'h17;
    localparam logic [5:0] c_ALU_SRLIW  = 6'h18;
    localparam logic [5:0] c_ALU_SRAIW  = 6'h19;
    localparam logic [5:0] c_ALU_ADDW   = 6'h1A;
    localparam logic [5:0] c_ALU_SUBW   = 6'h1B;
    localparam logic [5:0] c_ALU_SLLW   = 6'h1C;
    localparam logic [5:0] c_ALU_SRLW   = 6'h1D;
    localparam logic [5:0] c_ALU_SRAW   = 6'h1E;
    localparam logic [5:0] c_ALU_MUL    = 6'h1F;
    localparam logic [5:0] c_ALU_MULH   = 6'h20;
    localparam logic [5:0] c_ALU_MULHSU = 6'h21;
    localparam logic [5:0] c_ALU_MULHU  = 6'h22;
    localparam logic [5:0] c_ALU_DIV    = 6'h23;
    localparam logic [5:0] c_ALU_DIVU   = 6'h24;
    localparam logic [5:0] c_ALU_REM    = 6'h25;
    localparam logic [5:0] c_ALU_REMU   = 6'h26;
    localparam logic [5:0] c_ALU_MULW   = 6'h27;
    localparam logic [5:0] c_ALU_DIVW   = 6'h28;
    localparam logic [5:0] c_ALU_DIVUW  = 6'h29;
    localparam logic [5:0] c_ALU_REMW   = 6'h2A;
    localparam logic [5:0] c_ALU_REMUW  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DIV  = 2'b01,
        S_DONE = 2'b10
    } alu_state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_execute_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_execute_if
// Brief    : Decode-to-execute op handshake and registered result bus.
// Revision : 1.0
// ============================================================================
interface alu_execute_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_alu_control;
    logic [DATA_W-1:0] in_rs1_data;
    logic [DATA_W-1:0] in_rs2_data;
    logic [DATA_W-1:0] in_imm;
    logic              in_muxB_control;
    logic [4:0]        in_addressC;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_result;
    logic [4:0]        out_addressC;

    modport master (
        output in_valid, in_alu_control, in_rs1_data, in_rs2_data, in_imm,
               in_muxB_control, in_addressC, flush,
        input  in_ready, out_valid, out_result, out_addressC
    );

    modport slave (
        input  in_valid, in_alu_control, in_rs1_data, in_rs2_data, in_imm,
               in_muxB_control, in_addressC, flush,
        output in_ready, out_valid, out_result, out_addressC
    );
endinterface
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : Iterative restoring unsigned divider, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module div_iter #(
    parameter int ITERS = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_start,
    input  wire logic        i_abort,
    input  wire logic        i_is_word,
    input  wire logic [63:0] i_dividend,
    input  wire logic [63:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [63:0]      o_quotient,
    output logic [63:0]      o_remainder
);
    localparam int             CW         = $clog2(ITERS + 1);
    localparam logic [CW-1:0]  c_CNT_FULL = CW'(ITERS - 1);
    localparam logic [CW-1:0]  c_CNT_WORD = CW'(ITERS / 2 - 1);

    logic [63:0]   r_rem;
    logic [63:0]   r_quo;
    logic [63:0]   r_dvs;
    logic [CW-1:0] r_count;
    logic          r_busy;
    logic          r_done;

    logic [63:0] w_rem_src;
    logic [63:0] w_quo_src;
    logic [63:0] w_dvs_src;
    logic [64:0] w_shift;
    logic [64:0] w_diff;
    logic        w_fit;
    logic [63:0] w_rem_nxt;
    logic [63:0] w_quo_nxt;

    // The first step runs on the start edge straight from the operands; a
    // word dividend is pre-shifted so its MSB is the first bit consumed.
    assign w_rem_src = i_start ? 64'd0 : r_rem;
    assign w_quo_src = i_start ? (i_is_word ? {i_dividend[31:0], 32'd0} : i_dividend) : r_quo;
    assign w_dvs_src = i_start ? i_divisor : r_dvs;

    assign w_shift   = {w_rem_src, w_quo_src[63]};
    assign w_diff    = w_shift - {1'b0, w_dvs_src};
    assign w_fit     = ~w_diff[64];
    assign w_rem_nxt = w_fit ? w_diff[63:0] : w_shift[63:0];
    assign w_quo_nxt = {w_quo_src[62:0], w_fit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy  <= 1'b0;
                r_count <= '0;
            end else if (i_start) begin
                r_rem   <= w_rem_nxt;
                r_quo   <= w_quo_nxt;
                r_dvs   <= i_divisor;
                r_count <= i_is_word ? c_CNT_WORD : c_CNT_FULL;
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_rem   <= w_rem_nxt;
                r_quo   <= w_quo_nxt;
                r_count <= r_count - 1'b1;
                if (r_count == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;
endmodule
`default_nettype wire

// File: rtl/alu_execute.sv
`default_nettype none
// ============================================================================
// Module   : alu_execute
// Brief    : RV64IM execute stage: single-cycle ALU/MUL, iterative DIV/REM.
// Revision : 1.0
// ============================================================================
module alu_execute
    import alu_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DIV_ITERS      = 64
) (
    input  wire logic    clk,
    input  wire logic    reset,
    alu_execute_if.slave bus
);
    logic [BUS_DATA_WIDTH-1:0] w_a;
    logic [BUS_DATA_WIDTH-1:0] w_b;
    logic [5:0]                w_op;
    logic [127:0]              w_prod;
    logic                      w_mul_sa;
    logic                      w_mul_sb;
    logic [BUS_DATA_WIDTH-1:0] w_res;
    logic                      w_known;

    logic                      w_div_word;
    logic                      w_div_signed;
    logic                      w_div_rem;
    logic                      w_is_div;
    logic [BUS_DATA_WIDTH-1:0] w_dvd;
    logic [BUS_DATA_WIDTH-1:0] w_dvs;
    logic                      w_dvd_neg;
    logic                      w_dvs_neg;
    logic [BUS_DATA_WIDTH-1:0] w_dvd_mag;
    logic [BUS_DATA_WIDTH-1:0] w_dvs_mag;
    logic                      w_div_zero;
    logic                      w_div_ovf;
    logic                      w_div_special;
    logic [BUS_DATA_WIDTH-1:0] w_div_special_res;

    logic                      w_accept;
    logic                      w_start;
    logic                      w_div_busy;
    logic                      w_div_done;
    logic [BUS_DATA_WIDTH-1:0] w_div_quo;
    logic [BUS_DATA_WIDTH-1:0] w_div_rem_mag;
    logic [BUS_DATA_WIDTH-1:0] w_fin;
    logic [BUS_DATA_WIDTH-1:0] w_fin_res;

    alu_state_t                r_state;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [BUS_DATA_WIDTH-1:0] r_out_result;
    logic [4:0]                r_out_addr;
    logic                      r_q_neg;
    logic                      r_r_neg;
    logic                      r_is_rem;
    logic                      r_is_word;
    logic [4:0]                r_div_addr;

    assign w_op = bus.in_alu_control;
    assign w_a  = bus.in_rs1_data;
    assign w_b  = bus.in_muxB_control ? bus.in_imm : bus.in_rs2_data;

    // One 128-bit multiplier serves all variants by choosing operand extension.
    assign w_mul_sa = (w_op == c_ALU_MULH) || (w_op == c_ALU_MULHSU);
    assign w_mul_sb = (w_op == c_ALU_MULH);
    assign w_prod   = {{64{w_mul_sa & w_a[63]}}, w_a} * {{64{w_mul_sb & w_b[63]}}, w_b};

    assign w_div_word   = w_op inside {c_ALU_DIVW, c_ALU_DIVUW, c_ALU_REMW, c_ALU_REMUW};
    assign w_div_signed = w_op inside {c_ALU_DIV, c_ALU_REM, c_ALU_DIVW, c_ALU_REMW};
    assign w_div_rem    = w_op inside {c_ALU_REM, c_ALU_REMU, c_ALU_REMW, c_ALU_REMUW};
    assign w_is_div     = w_div_word || (w_op inside {c_ALU_DIV, c_ALU_DIVU, c_ALU_REM, c_ALU_REMU});

    assign w_dvd = w_div_word ? (w_div_signed ? sext32(w_a[31:0]) : {32'd0, w_a[31:0]}) : w_a;
    assign w_dvs = w_div_word ? (w_div_signed ? sext32(w_b[31:0]) : {32'd0, w_b[31:0]}) : w_b;
    assign w_dvd_neg = w_div_signed & w_dvd[63];
    assign w_dvs_neg = w_div_signed & w_dvs[63];
    assign w_dvd_mag = w_dvd_neg ? (~w_dvd + 64'd1) : w_dvd;
    assign w_dvs_mag = w_dvs_neg ? (~w_dvs + 64'd1) : w_dvs;

    assign w_div_zero    = (w_dvs == 64'd0);
    assign w_div_ovf     = w_div_signed && (w_dvs == {64{1'b1}}) &&
                           (w_dvd == (w_div_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign w_div_special = w_div_zero | w_div_ovf;
    assign w_div_special_res =
        w_div_zero ? (w_div_rem ? (w_div_word ? sext32(w_a[31:0]) : w_a) : {64{1'b1}})
                   : (w_div_rem ? 64'd0 : w_dvd);

    always_comb begin
        w_res   = '0;
        w_known = 1'b1;
        case (w_op)
            c_ALU_ADDI,  c_ALU_ADD:   w_res = w_a + w_b;
            c_ALU_SUB:                w_res = w_a - w_b;
            c_ALU_SLTI,  c_ALU_SLT:   w_res = {63'd0, $signed(w_a) < $signed(w_b)};
            c_ALU_SLTIU, c_ALU_SLTU:  w_res = {63'd0, w_a < w_b};
            c_ALU_XORI,  c_ALU_XOR:   w_res = w_a ^ w_b;
            c_ALU_ORI,   c_ALU_OR:    w_res = w_a | w_b;
            c_ALU_ANDI,  c_ALU_AND:   w_res = w_a & w_b;
            c_ALU_SLLI,  c_ALU_SLL:   w_res = w_a << w_b[5:0];
            c_ALU_SRLI,  c_ALU_SRL:   w_res = w_a >> w_b[5:0];
            c_ALU_SRAI,  c_ALU_SRA:   w_res = $signed(w_a) >>> w_b[5:0];
            c_ALU_ADDIW, c_ALU_ADDW:  w_res = sext32(w_a[31:0] + w_b[31:0]);
            c_ALU_SUBW:               w_res = sext32(w_a[31:0] - w_b[31:0]);
            c_ALU_SLLIW, c_ALU_SLLW:  w_res = sext32(w_a[31:0] << w_b[4:0]);
            c_ALU_SRLIW, c_ALU_SRLW:  w_res = sext32(w_a[31:0] >> w_b[4:0]);
            c_ALU_SRAIW, c_ALU_SRAW:  w_res = sext32($signed(w_a[31:0]) >>> w_b[4:0]);
            c_ALU_MUL:                w_res = w_prod[63:0];
            c_ALU_MULH, c_ALU_MULHSU, c_ALU_MULHU: w_res = w_prod[127:64];
            c_ALU_MULW:               w_res = sext32(w_prod[31:0]);
            c_ALU_DIV,  c_ALU_DIVU,  c_ALU_REM,  c_ALU_REMU,
            c_ALU_DIVW, c_ALU_DIVUW, c_ALU_REMW, c_ALU_REMUW: w_res = w_div_special_res;
            default:                  w_known = 1'b0;
        endcase
    end

    assign w_accept = bus.in_valid & bus.in_ready & ~bus.flush;
    assign w_start  = w_accept & w_known & w_is_div & ~w_div_special;

    div_iter #(
        .ITERS (DIV_ITERS)
    ) u_div_iter (
        .clk         (clk),
        .rst         (reset),
        .i_start     (w_start),
        .i_abort     (bus.flush),
        .i_is_word   (w_div_word),
        .i_dividend  (w_dvd_mag),
        .i_divisor   (w_dvs_mag),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem_mag)
    );

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    assign w_fin     = r_is_rem ? (r_r_neg ? (~w_div_rem_mag + 64'd1) : w_div_rem_mag)
                                : (r_q_neg ? (~w_div_quo + 64'd1) : w_div_quo);
    assign w_fin_res = r_is_word ? sext32(w_fin[31:0]) : w_fin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_addr   <= '0;
            r_q_neg      <= 1'b0;
            r_r_neg      <= 1'b0;
            r_is_rem     <= 1'b0;
            r_is_word    <= 1'b0;
            r_div_addr   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.flush) begin
                r_state    <= S_IDLE;
                r_in_ready <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                        if (w_start) begin
                            r_state    <= S_DIV;
                            r_in_ready <= 1'b0;
                            r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
                            r_r_neg    <= w_dvd_neg;
                            r_is_rem   <= w_div_rem;
                            r_is_word  <= w_div_word;
                            r_div_addr <= bus.in_addressC;
                        end else if (w_accept && w_known) begin
                            r_out_valid  <= 1'b1;
                            r_out_result <= w_res;
                            r_out_addr   <= bus.in_addressC;
                        end
                    end
                    S_DIV: begin
                        if (w_div_done) begin
                            r_state      <= S_DONE;
                            r_in_ready   <= 1'b1;
                            r_out_valid  <= 1'b1;
                            r_out_result <= w_fin_res;
                            r_out_addr   <= r_div_addr;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Never accept while the divider still owns its operands.
    assign bus.in_ready     = r_in_ready & ~w_div_busy;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_result   = r_out_result;
    assign bus.out_addressC = r_out_addr;
endmodule
`default_nettype wire

// File: tb/tb_alu_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_execute
// Brief    : Directed vector bench for the execute stage plus divide sequences.
// Revision : 1.0
// ============================================================================
module tb_alu_execute;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_execute_if #(.DATA_W(64)) bus ();

    alu_execute #(
        .BUS_DATA_WIDTH (64),
        .DIV_ITERS      (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        muxb;
        logic [4:0]  rd;
        logic        ev;
        logic [63:0] er;
        logic [4:0]  ea;
    } vec_t;

    vec_t vt[32];
    int   nv     = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic muxb, input logic [4:0] rd, input logic ev,
                        input logic [63:0] er);
        vt[nv].op   = op;
        vt[nv].a    = a;
        vt[nv].b    = b;
        vt[nv].muxb = muxb;
        vt[nv].rd   = rd;
        vt[nv].ev   = ev;
        vt[nv].er   = er;
        vt[nv].ea   = ev ? rd : ((nv > 0) ? vt[nv-1].ea : 5'd0);
        nv++;
    endtask

    // The unselected operand source carries the complement to expose mux errors.
    task automatic drive(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic muxb, input logic [4:0] rd);
        bus.in_valid        = 1'b1;
        bus.in_alu_control  = op;
        bus.in_rs1_data     = a;
        bus.in_rs2_data     = muxb ? ~b : b;
        bus.in_imm          = muxb ? b : ~b;
        bus.in_muxB_control = muxb;
        bus.in_addressC     = rd;
    endtask

    task automatic idle();
        bus.in_valid       = 1'b0;
        bus.in_alu_control = c_ALU_BUBBLE;
    endtask

    task automatic run_div(input string nm, input logic [5:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd,
                           input logic [63:0] exp, input int exp_lat);
        int k;
        int low;
        drive(op, a, b, 1'b0, rd);
        @(posedge clk);
        #1;
        idle();
        k   = 1;
        low = 0;
        while (bus.out_valid !== 1'b1 && k < 200) begin
            if (bus.in_ready === 1'b0) low++;
            @(posedge clk);
            #1;
            k++;
        end
        check({nm, " latency"}, 64'(k), 64'(exp_lat));
        check({nm, " ready_low"}, 64'(low), 64'(exp_lat - 1));
        check({nm, " ready_done"}, {63'd0, bus.in_ready}, 64'd1);
        check({nm, " result"}, bus.out_result, exp);
        check({nm, " addr"}, {59'd0, bus.out_addressC}, {59'd0, rd});
    endtask

    task automatic watch_quiet(input string nm, input int cycles);
        int nvalid;
        int nlow;
        nvalid = 0;
        nlow   = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) nvalid++;
            if (bus.in_ready !== 1'b1) nlow++;
        end
        check({nm, " late_valid"}, 64'(nvalid), 64'd0);
        check({nm, " ready_low"}, 64'(nlow), 64'd0);
    endtask

    task automatic single(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] exp);
        drive(c_ALU_ADD, a, b, 1'b0, rd);
        @(posedge clk);
        #1;
        idle();
        check({nm, " valid"}, {63'd0, bus.out_valid}, 64'd1);
        check({nm, " result"}, bus.out_result, exp);
        check({nm, " addr"}, {59'd0, bus.out_addressC}, {59'd0, rd});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        addv(c_ALU_ADD,    64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        addv(c_ALU_BUBBLE, 64'd1, 64'd1, 1'b0, 5'd9, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        addv(c_ALU_ADDIW,  64'h7FFF_FFFF, 64'd1, 1'b1, 5'd4, 1'b1, 64'hFFFF_FFFF_8000_0000);
        addv(6'h3F,        64'd1, 64'd1, 1'b0, 5'd9, 1'b0, 64'hFFFF_FFFF_8000_0000);
        addv(c_ALU_SUB,    64'd10, 64'd3, 1'b0, 5'd5, 1'b1, 64'd7);
        addv(c_ALU_SLT,    64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 5'd6, 1'b1, 64'd1);
        addv(c_ALU_SLTIU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 5'd7, 1'b1, 64'd0);
        addv(c_ALU_XORI,   64'hF0, 64'hFF, 1'b1, 5'd8, 1'b1, 64'h0F);
        addv(c_ALU_SRAI,   64'h8000_0000_0000_0000, 64'd4, 1'b1, 5'd9, 1'b1, 64'hF800_0000_0000_0000);
        addv(c_ALU_SRL,    64'h8000_0000_0000_0000, 64'd4, 1'b0, 5'd10, 1'b1, 64'h0800_0000_0000_0000);
        addv(c_ALU_SLL,    64'd1, 64'h43, 1'b0, 5'd11, 1'b1, 64'd8);
        addv(c_ALU_SRAW,   64'h8000_0000, 64'h21, 1'b0, 5'd12, 1'b1, 64'hFFFF_FFFF_C000_0000);
        addv(c_ALU_SRLIW,  64'h8000_0000, 64'd1, 1'b1, 5'd13, 1'b1, 64'h4000_0000);
        addv(c_ALU_SLLIW,  64'd1, 64'd31, 1'b1, 5'd14, 1'b1, 64'hFFFF_FFFF_8000_0000);
        addv(c_ALU_ANDI,   64'hFF00, 64'h0FF0, 1'b1, 5'd15, 1'b1, 64'h0F00);
        addv(c_ALU_OR,     64'hFF00, 64'h0FF0, 1'b0, 5'd16, 1'b1, 64'hFFF0);
        addv(c_ALU_SUBW,   64'd0, 64'd1, 1'b0, 5'd17, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        addv(c_ALU_MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5'd18, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA);
        addv(c_ALU_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd19, 1'b1, 64'd0);
        addv(c_ALU_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd20, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        addv(c_ALU_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 5'd21, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        addv(c_ALU_MULW,   64'h4000_0000, 64'd2, 1'b0, 5'd22, 1'b1, 64'hFFFF_FFFF_8000_0000);
        addv(c_ALU_DIVU,   64'd7, 64'd0, 1'b0, 5'd23, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        addv(c_ALU_REMU,   64'd7, 64'd0, 1'b0, 5'd24, 1'b1, 64'd7);
        addv(c_ALU_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd25, 1'b1, 64'h8000_0000_0000_0000);
        addv(c_ALU_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd26, 1'b1, 64'd0);
        addv(c_ALU_DIVUW,  64'd5, 64'd0, 1'b0, 5'd27, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        addv(c_ALU_REMW,   64'h1_8000_0000, 64'd0, 1'b0, 5'd28, 1'b1, 64'hFFFF_FFFF_8000_0000);
        addv(c_ALU_DIVW,   64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 5'd29, 1'b1, 64'hFFFF_FFFF_8000_0000);
        addv(c_ALU_REMW,   64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 5'd30, 1'b1, 64'd0);

        reset = 1'b1;
        bus.flush           = 1'b0;
        bus.in_rs1_data     = '0;
        bus.in_rs2_data     = '0;
        bus.in_imm          = '0;
        bus.in_muxB_control = 1'b0;
        bus.in_addressC     = '0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset out_result", bus.out_result, 64'd0);
        check("reset out_addressC", {59'd0, bus.out_addressC}, 64'd0);
        check("reset in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Back-to-back: one vector presented every cycle.
        for (int i = 0; i < nv; i++) begin
            drive(vt[i].op, vt[i].a, vt[i].b, vt[i].muxb, vt[i].rd);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid", i), {63'd0, bus.out_valid}, {63'd0, vt[i].ev});
            check($sformatf("vec%0d result", i), bus.out_result, vt[i].er);
            check($sformatf("vec%0d addr", i), {59'd0, bus.out_addressC}, {59'd0, vt[i].ea});
            check($sformatf("vec%0d ready", i), {63'd0, bus.in_ready}, 64'd1);
        end
        idle();
        @(posedge clk);
        #1;
        check("idle valid", {63'd0, bus.out_valid}, 64'd0);

        run_div("div", c_ALU_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        @(posedge clk);
        #1;
        check("div pulse", {63'd0, bus.out_valid}, 64'd0);
        run_div("rem", c_ALU_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_div("rem_pn", c_ALU_REM, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd7, 64'd2, 65);
        run_div("divu", c_ALU_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd3, 64'h0FFF_FFFF_FFFF_FFFF, 65);
        run_div("divw", c_ALU_DIVW, 64'hFFFF_FFEC, 64'd3, 5'd4, 64'hFFFF_FFFF_FFFF_FFFA, 33);
        run_div("remuw", c_ALU_REMUW, 64'd100, 64'd7, 5'd5, 64'd2, 33);
        // Still in the DONE cycle: an op presented now must be accepted.
        single("done_add", 64'd1, 64'd2, 5'd6, 64'd3);

        // Reset during DIV cycle 10.
        drive(c_ALU_DIVU, 64'd100, 64'd3, 1'b0, 5'd8);
        @(posedge clk);
        #1;
        idle();
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("rst_abort busy", {63'd0, bus.in_ready}, 64'd0);
        reset = 1'b1;
        #1;
        check("rst_abort valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_abort ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_abort result", bus.out_result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        watch_quiet("rst_abort", 80);
        single("rst_add", 64'd4, 64'd5, 5'd9, 64'd9);

        // Flush during DIV cycle 10, with an op presented in the same cycle.
        drive(c_ALU_DIVU, 64'd100, 64'd3, 1'b0, 5'd10);
        @(posedge clk);
        #1;
        idle();
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        drive(c_ALU_ADD, 64'd1, 64'd1, 1'b0, 5'd11);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        idle();
        check("flush valid", {63'd0, bus.out_valid}, 64'd0);
        check("flush ready", {63'd0, bus.in_ready}, 64'd1);
        watch_quiet("flush", 80);
        single("flush_add", 64'd2, 64'd3, 5'd12, 64'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_execute.md
# alu_execute

Execute stage of the RV64IM core, directly downstream of the decode stage. Consumes the decoded ALU op code, operand values read for the decoded source registers, sign-extended immediate and operand-B select. Produces a registered 64-bit result tagged with the destination register. Single-cycle ops complete in one cycle. Divide/remainder ops run in an iterative divider, and upstream is stalled through a ready handshake while it runs.

## Interface
- BUS_DATA_WIDTH, 64, datapath width; only 64 is supported.
- DIV_ITERS, 64, quotient bits produced by the divider per 64-bit op; W ops use DIV_ITERS/2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  decoded op present this cycle.
- in_ready  out  1  block accepts an op this cycle; transfer occurs when in_valid && in_ready.
- in_alu_control  in  6  op code from decode; 6'b000000 = bubble (accepted, produces no output).
- in_rs1_data  in  64  operand A value.
- in_rs2_data  in  64  register operand B value.
- in_imm  in  64  sign-extended immediate.
- in_muxB_control  in  1  1 selects in_imm as operand B, 0 selects in_rs2_data.
- in_addressC  in  5  destination register.
- flush  in  1  synchronous squash of any in-flight op.
- out_valid  out  1  result valid; pulses for exactly one cycle per non-bubble op.
- out_result  out  64  result.
- out_addressC  out  5  destination register of out_result.

## Operation
- B = in_muxB_control ? in_imm : in_rs2_data.
- Op codes: 000001 addi, 000010 slti, 000011 sltiu, 000100 xori, 000101 ori, 000110 andi, 000111 slli, 001000 srli, 001001 srai.
- Op codes: 001100 add, 001101 sub, 001110 sll, 001111 slt, 010000 sltu, 010001 xor, 010010 srl, 010011 sra, 010100 or, 010101 and.
- Op codes: 010110 addiw, 010111 slliw, 011000 srliw, 011001 sraiw, 011010 addw, 011011 subw, 011100 sllw, 011101 srlw, 011110 sraw.
- Op codes: 011111 mul, 100000 mulh, 100001 mulhsu, 100010 mulhu, 100111 mulw, 100011 div, 100100 divu, 100101 rem, 100110 remu, 101000 divw, 101001 divuw, 101010 remw, 101011 remuw.
- Unlisted codes are treated as bubbles.
- 64-bit shifts use B[5:0]; W shifts use B[4:0] applied to A[31:0].
- All W results are the 32-bit result sign-extended to 64 bits.
- slt/sltu produce 0 or 1.
- Multiplies are single-cycle; mulh, mulhsu and mulhu take bits [127:64] of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
- Division follows RISC-V semantics and is evaluated on 32-bit operands for W ops:
  - Divide by zero: quotient all ones; remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = dividend; remainder 0.
  - Both special cases complete in single-cycle latency; the divider is not started.
- FSM states:
  - IDLE: in_ready=1. A non-special divide op moves to DIV.
  - DIV: in_ready=0. One restoring-division step per cycle, on unsigned magnitudes; signs are fixed up at the end. After DIV_ITERS (or DIV_ITERS/2) steps, move to DONE.
  - DONE: register the result, out_valid=1, in_ready=1, return to IDLE. An op accepted in DONE is processed normally.

## Timing
- Reset values: out_valid=0, out_result=0, out_addressC=0, in_ready=1, state=IDLE, divider registers 0.
- Single-cycle ops: accepted at edge T; out_valid, out_result and out_addressC are valid after edge T, i.e. during cycle T+1.
- 64-bit divide: accepted at T; in_ready=0 during cycles T+1..T+64; out_valid is asserted during cycle T+65.
- W divide: out_valid is asserted during cycle T+33.
- Back-to-back single-cycle ops sustain 1 op/cycle.
- Bubbles and idle cycles drive out_valid=0; out_result holds its last value.
- flush: clears out_valid at the next edge, aborts DIV/DONE to IDLE, and discards any op presented in the same cycle.
- Reset mid-divide: immediately returns to IDLE with all outputs at reset values; no late result is emitted.

## Structure
- Package alu_pkg: alu_control localparams for every op code above, plus the FSM state enum.
- Sub-module div_iter: iterative unsigned divider with a start/busy/done handshake and a width select (64/32). Sign handling and special cases stay in the top level.

## Test plan
- add: A=5, rs2=0xFFFF_FFFF_FFFF_FFF9, muxB=0, addressC=3 -> next cycle out_valid=1, result 0xFFFF_FFFF_FFFF_FFFE, addressC=3.
- addiw: A=0x7FFF_FFFF, imm=1, muxB=1 -> result 0xFFFF_FFFF_8000_0000.
- div: A=−20, B=3 -> in_ready low 64 cycles, result −6. rem with the same operands -> −2.
- divu: A=7, B=0 -> 1-cycle result 0xFFFF_FFFF_FFFF_FFFF. remu with the same operands -> 7.
- div: A=0x8000_0000_0000_0000, B=−1 -> result 0x8000_0000_0000_0000, 1-cycle. rem with the same operands -> 0.
- Abort mid-divide: start divu, assert reset (second run: flush) in DIV cycle 10 -> out_valid stays 0, in_ready=1. A following add completes normally.
